alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Multi-cycle controller that sits between instruction decode and the 32-bit ALU. It accepts one data-processing command at a time over a valid/ready handshake and evaluates the 4-bit condition code against its own NZCV register. It then drives the ALU opcode, operand and carry inputs, captures the result and flags, and issues a register write-back. It owns the architectural NZCV flags register.

Parameters:
WIDTH, 32, datapath width of operands, result and write-back data
RD_W, 4, destination register index width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (IDLE only)
cmd_op  in  4  data-processing opcode (0000 AND … 1111 MVN)
cmd_s  in  1  set-flags request
cmd_cond  in  4  condition code
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
cmd_rd  in  RD_W  destination register
alu_opcode  out  5  to ALU opcode
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_carry  out  1  to ALU carry input
alu_result  in  WIDTH  from ALU
alu_z, alu_n, alu_c, alu_v  in  1 each  ALU flags
wb_valid  out  1  one-cycle write-back strobe
wb_rd  out  RD_W  write-back register index
wb_data  out  WIDTH  write-back data
flags_nzcv  out  4  architectural flags {N,Z,C,V}
done  out  1  one-cycle completion pulse (executed or skipped)
skipped  out  1  valid with done: condition failed

Behaviour:
- Reset values: state IDLE, cmd_ready 1, wb_valid 0, done 0, skipped 0, wb_rd 0, wb_data 0, flags_nzcv 0000, alu_opcode 00000, alu_a 0, alu_b 0, alu_carry 0. Reset in any state aborts the command with no wb_valid or done, and clears the flags.
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch cmd_op, cmd_s, cmd_a, cmd_b and cmd_rd, then evaluate cmd_cond against the current flags. Pass -> EXEC. Fail -> SKIP.
  - EXEC: drive the ALU from the latched fields. At the clock edge, capture alu_result and alu_* flags. Next state WB.
  - WB: done=1. wb_valid=1 if the op writes. Apply the flag update. Next state IDLE.
  - SKIP: done=1, skipped=1, no write-back, flags unchanged. Next state IDLE.
- Latency: accept at edge T; wb_valid/done high in cycle T+2; cmd_ready high again in T+3. Throughput is one command per 3 cycles (2 cycles for skipped commands).
- cmd_valid while cmd_ready=0 is ignored. The command is not latched, and the upstream holds it until it is accepted.
- ALU opcode mapping is {1'b0, cmd_op}, except the test class:
  - TST(1000) drives 00000.
  - TEQ(1001) drives 00001.
  - CMP(1010) drives 00010.
  - CMN(1011) drives 00100.
  - The test class never writes back and always updates flags, regardless of cmd_s.
- alu_carry is flags_nzcv C during EXEC.
- The ALU inputs are held at their last values outside EXEC.
- Flag update (S=1 or test class):
  - N and Z are always taken from the ALU.
  - C is taken from alu_c.
  - V is taken from alu_v only for arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN). Logical ops keep V.
  - S=0 non-test ops leave the flags unchanged.
- Condition evaluation uses registered flags only. Flags written in WB are visible to a command accepted in the next IDLE cycle.
  - EQ Z, NE !Z
  - CS C, CC !C
  - MI N, PL !N
  - VS V, VC !V
  - HI C&!Z, LS !C|Z
  - GE N==V, LT N!=V
  - GT !Z&(N==V), LE Z|(N!=V)
  - AL always, 1111 never (skip)
- wb_rd and wb_data hold their values after WB until the next write-back.

Optional Feature:
- Macro ALU_SEQ_STATS_EN. When defined, it adds output ports exec_count[15:0] and skip_count[15:0].
  - exec_count increments on done&!skipped.
  - skip_count increments on done&skipped.
  - Both counters saturate at 0xFFFF and clear on reset.
- When undefined, neither the ports nor the counters exist, and the behaviour is otherwise identical.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the 4-bit data-processing opcode constants;
  - the 5-bit ALU opcode constants;
  - the 16 condition-code constants;
  - the state encoding (IDLE, EXEC, WB, SKIP).
- One combinational sub-module, cond_eval (cond[3:0], nzcv[3:0] -> pass), is natural and is reused by the branch unit.

Test Plan:
- ADDS AL, A=0x7FFFFFFF, B=1 -> wb_valid at T+2, wb_data=0x80000000, flags_nzcv=1001.
- CMP AL, A=5, B=5 -> done at T+2, wb_valid=0, Z=1, N=0. Then MOVEQ rd=3, B=0x1234 -> wb_rd=3, wb_data=0x1234.
- After Z=1, MOVNE -> done and skipped at T+1, no wb_valid, flags unchanged, cmd_ready back at T+2.
- ADD without S, A=0xFFFFFFFF, B=1 -> wb_data=0, flags_nzcv unchanged from the prior value.
- Accept ADDS, assert reset during EXEC -> no wb_valid or done, flags 0000, cmd_ready=1 the cycle after reset.
- cmd_valid held high back-to-back for 3 commands -> exactly 3 accepts, spaced 3 cycles apart. With ALU_SEQ_STATS_EN defined, exec_count=3.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU op sequencer: data-processing and ALU opcodes,
// condition codes, FSM states and small opcode-classification helpers.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_EOR = 5'b00001;
  localparam logic [4:0] ALU_SUB = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  function automatic logic is_test_op(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

  function automatic logic is_arith_op(input logic [3:0] op);
    logic r;
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: r = 1'b1;
      default:                        r = 1'b0;
    endcase
    return r;
  endfunction

  // Test-class ops reuse the plain logical/arithmetic ALU encodings.
  function automatic logic [4:0] map_alu_opcode(input logic [3:0] op);
    logic [4:0] r;
    case (op)
      OP_TST:  r = ALU_AND;
      OP_TEQ:  r = ALU_EOR;
      OP_CMP:  r = ALU_SUB;
      OP_CMN:  r = ALU_ADD;
      default: r = {1'b0, op};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_cond_eval.sv
// Combinational condition-code evaluator (cond_eval): cond against {N,Z,C,V}.
// Shared with the branch unit.
module cond_eval
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = nzcv;

  // Condition table; NV never passes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = !z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = !c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = !n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = !v_s;
      COND_HI: pass = c_s && !z_s;
      COND_LS: pass = !c_s || z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = !z_s && (n_s == v_s);
      COND_LE: pass = z_s || (n_s != v_s);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU command sequencer owning the NZCV flags register.
// Optional ALU_SEQ_STATS_EN adds saturating exec/skip counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_s,
  input  logic [3:0]       cmd_cond,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [RD_W-1:0]  cmd_rd,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_carry,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             wb_valid,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [3:0]       flags_nzcv,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]      exec_count,
  output logic [15:0]      skip_count,
`endif
  output logic             done,
  output logic             skipped
);

  state_e           state_q;
  logic             ready_q;
  logic [3:0]       op_q;
  logic             s_q;
  logic [RD_W-1:0]  rd_q;
  logic [4:0]       alu_opcode_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic             alu_carry_q;
  logic             wb_valid_q;
  logic [RD_W-1:0]  wb_rd_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [3:0]       flags_q;
  logic             done_q;
  logic             skipped_q;
  logic             cond_pass_s;

  cond_eval u_cond_eval (
    .cond (cmd_cond),
    .nzcv (flags_q),
    .pass (cond_pass_s)
  );

  // Sequencer FSM; result and flags land at the EXEC->WB edge so they are visible with done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      op_q         <= 4'b0000;
      s_q          <= 1'b0;
      rd_q         <= '0;
      alu_opcode_q <= 5'b00000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_carry_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      flags_q      <= 4'b0000;
      done_q       <= 1'b0;
      skipped_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      skipped_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            s_q     <= cmd_s;
            rd_q    <= cmd_rd;
            ready_q <= 1'b0;
            if (cond_pass_s) begin
              state_q      <= ST_EXEC;
              alu_opcode_q <= map_alu_opcode(cmd_op);
              alu_a_q      <= cmd_a;
              alu_b_q      <= cmd_b;
              alu_carry_q  <= flags_q[1];
            end else begin
              state_q   <= ST_SKIP;
              done_q    <= 1'b1;
              skipped_q <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          state_q <= ST_WB;
          done_q  <= 1'b1;
          if (!is_test_op(op_q)) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= alu_result;
          end else begin
            wb_valid_q <= 1'b0;
          end
          // Logical ops keep V; only arithmetic ops take the ALU overflow.
          if (s_q || is_test_op(op_q)) begin
            flags_q <= {alu_n, alu_z, alu_c, is_arith_op(op_q) ? alu_v : flags_q[0]};
          end else begin
            flags_q <= flags_q;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        ST_SKIP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] exec_cnt_q;
  logic [15:0] skip_cnt_q;

  // Saturating completion counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_cnt_q <= 16'h0000;
      skip_cnt_q <= 16'h0000;
    end else begin
      if (done_q && !skipped_q && (exec_cnt_q != 16'hFFFF)) begin
        exec_cnt_q <= exec_cnt_q + 16'h0001;
      end else begin
        exec_cnt_q <= exec_cnt_q;
      end
      if (done_q && skipped_q && (skip_cnt_q != 16'hFFFF)) begin
        skip_cnt_q <= skip_cnt_q + 16'h0001;
      end else begin
        skip_cnt_q <= skip_cnt_q;
      end
    end
  end

  assign exec_count = exec_cnt_q;
  assign skip_count = skip_cnt_q;
`endif

  assign cmd_ready  = ready_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_carry  = alu_carry_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign flags_nzcv = flags_q;
  assign done       = done_q;
  assign skipped    = skipped_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; inputs driven and outputs
// sampled on the falling clock edge. Define ALU_SEQ_STATS_EN to cover the counters.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        cmd_s;
  logic [3:0]  cmd_cond;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_rd;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_carry;
  logic [31:0] alu_result;
  logic        alu_z, alu_n, alu_c, alu_v;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  flags_nzcv;
  logic        done;
  logic        skipped;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] exec_count;
  logic [15:0] skip_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(32), .RD_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_s      (cmd_s),
    .cmd_cond   (cmd_cond),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_rd     (cmd_rd),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_carry  (alu_carry),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .flags_nzcv (flags_nzcv),
`ifdef ALU_SEQ_STATS_EN
    .exec_count (exec_count),
    .skip_count (skip_count),
`endif
    .done       (done),
    .skipped    (skipped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command before the next rising edge, then return in the EXEC/SKIP cycle.
  task automatic issue(input logic [3:0] op, input logic s, input logic [3:0] cond,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    cmd_op = op; cmd_s = s; cmd_cond = cond; cmd_a = a; cmd_b = b; cmd_rd = rd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic set_alu(input logic [31:0] r, input logic n, input logic z,
                         input logic c, input logic v);
    alu_result = r; alu_n = n; alu_z = z; alu_c = c; alu_v = v;
  endtask

  int acc_cyc[3];
  int n_acc;
  int n_done;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_s = 1'b0; cmd_cond = 4'h0;
    cmd_a = 32'h0; cmd_b = 32'h0; cmd_rd = 4'h0;
    set_alu(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",   {31'd0, cmd_ready},  32'd1);
    chk("rst_wbvalid", {31'd0, wb_valid},   32'd0);
    chk("rst_done",    {31'd0, done},       32'd0);
    chk("rst_skipped", {31'd0, skipped},    32'd0);
    chk("rst_flags",   {28'd0, flags_nzcv}, 32'd0);
    chk("rst_opcode",  {27'd0, alu_opcode}, 32'd0);
    chk("rst_alu_a",   alu_a,               32'd0);
    chk("rst_alu_b",   alu_b,               32'd0);
    chk("rst_carry",   {31'd0, alu_carry},  32'd0);
    chk("rst_wbrd",    {28'd0, wb_rd},      32'd0);
    chk("rst_wbdata",  wb_data,             32'd0);

    // ADDS AL 0x7FFFFFFF + 1: signed overflow into N.
    issue(4'b0100, 1'b1, 4'b1110, 32'h7FFF_FFFF, 32'h0000_0001, 4'd1);
    chk("adds_exec_ready", {31'd0, cmd_ready},  32'd0);
    chk("adds_opcode",     {27'd0, alu_opcode}, 32'h04);
    chk("adds_alu_a",      alu_a,               32'h7FFF_FFFF);
    chk("adds_alu_b",      alu_b,               32'h0000_0001);
    chk("adds_carry",      {31'd0, alu_carry},  32'd0);
    chk("adds_exec_done",  {31'd0, done},       32'd0);
    set_alu(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("adds_wbvalid",    {31'd0, wb_valid},   32'd1);
    chk("adds_done",       {31'd0, done},       32'd1);
    chk("adds_skipped",    {31'd0, skipped},    32'd0);
    chk("adds_wbrd",       {28'd0, wb_rd},      32'd1);
    chk("adds_wbdata",     wb_data,             32'h8000_0000);
    chk("adds_flags",      {28'd0, flags_nzcv}, 32'b1001);
    chk("adds_wb_ready",   {31'd0, cmd_ready},  32'd0);
    @(negedge clk);
    chk("adds_ready_back", {31'd0, cmd_ready},  32'd1);
    chk("adds_done_low",   {31'd0, done},       32'd0);
    chk("adds_wbv_low",    {31'd0, wb_valid},   32'd0);
    chk("adds_wbdata_hold", wb_data,            32'h8000_0000);

    // CMP AL 5,5: flags only, no write-back, wb regs hold.
    issue(4'b1010, 1'b0, 4'b1110, 32'd5, 32'd5, 4'd7);
    chk("cmp_opcode",  {27'd0, alu_opcode}, 32'h02);
    set_alu(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("cmp_done",    {31'd0, done},       32'd1);
    chk("cmp_wbvalid", {31'd0, wb_valid},   32'd0);
    chk("cmp_flags",   {28'd0, flags_nzcv}, 32'b0110);
    chk("cmp_wbrd",    {28'd0, wb_rd},      32'd1);
    chk("cmp_wbdata",  wb_data,             32'h8000_0000);
    @(negedge clk);

    // MOVEQ rd=3: passes on Z=1, carry-in reflects C=1, S=0 leaves flags.
    issue(4'b1101, 1'b0, 4'b0000, 32'h0, 32'h0000_1234, 4'd3);
    chk("moveq_opcode", {27'd0, alu_opcode}, 32'h0D);
    chk("moveq_carry",  {31'd0, alu_carry},  32'd1);
    chk("moveq_skip",   {31'd0, skipped},    32'd0);
    set_alu(32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("moveq_wbvalid", {31'd0, wb_valid},   32'd1);
    chk("moveq_wbrd",    {28'd0, wb_rd},      32'd3);
    chk("moveq_wbdata",  wb_data,             32'h0000_1234);
    chk("moveq_flags",   {28'd0, flags_nzcv}, 32'b0110);
    @(negedge clk);

    // MOVNE with Z=1: skipped, ALU inputs held.
    issue(4'b1101, 1'b0, 4'b0001, 32'h0, 32'h0000_DEAD, 4'd4);
    chk("movne_done",    {31'd0, done},       32'd1);
    chk("movne_skipped", {31'd0, skipped},    32'd1);
    chk("movne_wbvalid", {31'd0, wb_valid},   32'd0);
    chk("movne_ready",   {31'd0, cmd_ready},  32'd0);
    chk("movne_flags",   {28'd0, flags_nzcv}, 32'b0110);
    chk("movne_alu_b",   alu_b,               32'h0000_1234);
    @(negedge clk);
    chk("movne_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("movne_done_low",   {31'd0, done},      32'd0);
    chk("movne_wbrd_hold",  {28'd0, wb_rd},     32'd3);

    // ANDS: logical op keeps V even though the ALU reports V=1.
    issue(4'b0000, 1'b1, 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd2);
    set_alu(32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("ands_flags",  {28'd0, flags_nzcv}, 32'b1000);
    chk("ands_wbdata", wb_data,             32'h8000_0000);
    @(negedge clk);

    // GT with N!=V fails; NV always fails.
    issue(4'b1101, 1'b0, 4'b1100, 32'h0, 32'h1, 4'd6);
    chk("movgt_skipped", {31'd0, skipped}, 32'd1);
    @(negedge clk);
    issue(4'b1101, 1'b0, 4'b1111, 32'h0, 32'h1, 4'd6);
    chk("movnv_skipped", {31'd0, skipped}, 32'd1);
    @(negedge clk);

    // ADD without S on AL: result written, flags unchanged despite ALU flags.
    issue(4'b0100, 1'b0, 4'b1110, 32'hFFFF_FFFF, 32'h0000_0001, 4'd5);
    chk("add_skip",  {31'd0, skipped}, 32'd0);
    set_alu(32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_wbvalid", {31'd0, wb_valid},   32'd1);
    chk("add_wbrd",    {28'd0, wb_rd},      32'd5);
    chk("add_wbdata",  wb_data,             32'h0);
    chk("add_flags",   {28'd0, flags_nzcv}, 32'b1000);
    @(negedge clk);

    // ADDS aborted by reset during EXEC.
    issue(4'b0100, 1'b1, 4'b1110, 32'h1, 32'h1, 4'd9);
    set_alu(32'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_wbvalid", {31'd0, wb_valid},   32'd0);
    chk("abort_done",    {31'd0, done},       32'd0);
    chk("abort_flags",   {28'd0, flags_nzcv}, 32'd0);
    chk("abort_ready",   {31'd0, cmd_ready},  32'd1);
    @(negedge clk);
    chk("abort_done2",   {31'd0, done},       32'd0);
    chk("abort_wbv2",    {31'd0, wb_valid},   32'd0);

    // Back-to-back: valid held high across three commands.
    set_alu(32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0);
    cmd_op = 4'b0100; cmd_s = 1'b0; cmd_cond = 4'b1110;
    cmd_a = 32'h1; cmd_b = 32'h2; cmd_rd = 4'd8;
    cmd_valid = 1'b1;
    n_acc = 0;
    n_done = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (done) n_done++;
      if (n_acc == 3) cmd_valid = 1'b0;
      else if (cmd_valid && cmd_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", n_acc,                 32'd3);
    chk("b2b_gap01",   acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("b2b_gap12",   acc_cyc[2] - acc_cyc[1], 32'd3);
    chk("b2b_dones",   n_done,                32'd3);
    chk("b2b_wbdata",  wb_data,               32'h0000_00A5);
`ifdef ALU_SEQ_STATS_EN
    chk("stats_exec",  {16'd0, exec_count},   32'd3);
    chk("stats_skip",  {16'd0, skip_count},   32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
